// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: operation mode encodings.
package univ_shift_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

endpackage

// File: rtl/shift_fill_cnt.sv
// Saturating count of valid bits held in the shift register, plus the full flag.
module shift_fill_cnt #(
   parameter  int WIDTH = 8,
   localparam int FW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          load,
   output logic [FW-1:0] fill,
   output logic          full
);

   localparam logic [FW-1:0] FULL_VAL = FW'(WIDTH);

   logic [FW-1:0] fill_r;

   // Fill counter: load sets it to WIDTH, shifts count up and stop at WIDTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_r <= {FW{1'b0}};
      end else if (load) begin
         fill_r <= FULL_VAL;
      end else if (inc && (fill_r != FULL_VAL)) begin
         fill_r <= fill_r + {{(FW-1){1'b0}}, 1'b1};
      end else begin
         fill_r <= fill_r;
      end
   end

   assign fill = fill_r;
   assign full = (fill_r == FULL_VAL);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left with serial in/out, parallel load,
// with a fill tracker so that only bits shifted in (or loaded) are reported valid on exit.
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int FW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             din_r,
   input  logic             din_l,
   input  logic [WIDTH-1:0] pdin,
   output logic [WIDTH-1:0] pout,
   output logic             sout,
   output logic             sout_vld,
   output logic [FW-1:0]    fill,
   output logic             full
);

   logic [WIDTH-1:0] data_r;
   logic             sout_r;
   logic             vld_r;
   logic             inc_s;
   logic             load_s;
   logic             full_s;

   // Decode which fill-counter action this cycle's operation requests.
   always_comb begin
      inc_s  = 1'b0;
      load_s = 1'b0;
      if (en) begin
         case (mode)
            MODE_SHR:  inc_s  = 1'b1;
            MODE_SHL:  inc_s  = 1'b1;
            MODE_LOAD: load_s = 1'b1;
            default: begin
               inc_s  = 1'b0;
               load_s = 1'b0;
            end
         endcase
      end else begin
         inc_s  = 1'b0;
         load_s = 1'b0;
      end
   end

   // Data path; sout_vld reflects whether the register was full before this shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r <= {WIDTH{1'b0}};
         sout_r <= 1'b0;
         vld_r  <= 1'b0;
      end else if (en) begin
         case (mode)
            MODE_SHR: begin
               data_r <= {din_r, data_r[WIDTH-1:1]};
               sout_r <= data_r[0];
               vld_r  <= full_s;
            end
            MODE_SHL: begin
               data_r <= {data_r[WIDTH-2:0], din_l};
               sout_r <= data_r[WIDTH-1];
               vld_r  <= full_s;
            end
            MODE_LOAD: begin
               data_r <= pdin;
               vld_r  <= 1'b0;
            end
            default: begin
               vld_r  <= 1'b0;
            end
         endcase
      end else begin
         vld_r <= 1'b0;
      end
   end

   shift_fill_cnt #(.WIDTH(WIDTH)) u_fill_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc_s),
      .load (load_s),
      .fill (fill),
      .full (full_s)
   );

   assign pout     = data_r;
   assign sout     = sout_r;
   assign sout_vld = vld_r;
   assign full     = full_s;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench: WIDTH=8 and WIDTH=16 instances driven in parallel and compared
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_univ_shift_reg;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic        din_r;
   logic        din_l;
   logic [15:0] pdin_s;

   logic [7:0]  pout8;
   logic        sout8, vld8, full8;
   logic [3:0]  fill8;
   logic [15:0] pout16;
   logic        sout16, vld16, full16;
   logic [4:0]  fill16;

   int n_checks;
   int n_fail;
   bit chk_en;

   // Behavioural model state: index 0 is the 8-bit register, index 1 the 16-bit one.
   logic [63:0] m_reg  [2];
   logic        m_sout [2];
   logic        m_vld  [2];
   int          m_fill [2];
   int          mw     [2];

   univ_shift_reg #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .din_r(din_r), .din_l(din_l),
      .pdin(pdin_s[7:0]), .pout(pout8), .sout(sout8), .sout_vld(vld8),
      .fill(fill8), .full(full8)
   );

   univ_shift_reg #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .din_r(din_r), .din_l(din_l),
      .pdin(pdin_s), .pout(pout16), .sout(sout16), .sout_vld(vld16),
      .fill(fill16), .full(full16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         logic [63:0] mask;
         int w;
         w    = mw[k];
         mask = (64'd1 << w) - 64'd1;
         if (rst) begin
            m_reg[k] = 64'd0; m_sout[k] = 1'b0; m_vld[k] = 1'b0; m_fill[k] = 0;
         end else if (en && mode == 2'd1) begin
            m_sout[k] = m_reg[k][0];
            m_vld[k]  = (m_fill[k] == w);
            m_reg[k]  = ((64'(din_r) << (w - 1)) | (m_reg[k] >> 1)) & mask;
            m_fill[k] = (m_fill[k] + 1 > w) ? w : m_fill[k] + 1;
         end else if (en && mode == 2'd2) begin
            m_sout[k] = m_reg[k][w-1];
            m_vld[k]  = (m_fill[k] == w);
            m_reg[k]  = ((m_reg[k] << 1) | 64'(din_l)) & mask;
            m_fill[k] = (m_fill[k] + 1 > w) ? w : m_fill[k] + 1;
         end else if (en && mode == 2'd3) begin
            m_reg[k]  = 64'(pdin_s) & mask;
            m_fill[k] = w;
            m_vld[k]  = 1'b0;
         end else begin
            m_vld[k]  = 1'b0;
         end
      end
   endtask

   // Apply inputs for one clock edge, advance the model, then step clear of the edge.
   task automatic step(input logic r, input logic e, input logic [1:0] m,
                       input logic dr, input logic dl, input logic [15:0] pd);
      rst = r; en = e; mode = m; din_r = dr; din_l = dl; pdin_s = pd;
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("pout8",  64'(pout8),  m_reg[0]);
         check("sout8",  64'(sout8),  64'(m_sout[0]));
         check("vld8",   64'(vld8),   64'(m_vld[0]));
         check("fill8",  64'(fill8),  64'(m_fill[0]));
         check("full8",  64'(full8),  64'(m_fill[0] == 8));
         check("pout16", 64'(pout16), m_reg[1]);
         check("sout16", 64'(sout16), 64'(m_sout[1]));
         check("vld16",  64'(vld16),  64'(m_vld[1]));
         check("fill16", 64'(fill16), 64'(m_fill[1]));
         check("full16", 64'(full16), 64'(m_fill[1] == 16));
      end
   end

   initial begin
      logic [7:0] seq;
      logic [7:0] keep_pout;
      n_checks = 0; n_fail = 0; chk_en = 1'b0;
      mw[0] = 8; mw[1] = 16;
      for (int k = 0; k < 2; k++) begin
         m_reg[k] = 64'd0; m_sout[k] = 1'b0; m_vld[k] = 1'b0; m_fill[k] = 0;
      end
      rst = 1'b1; en = 1'b0; mode = 2'd0; din_r = 1'b0; din_l = 1'b0; pdin_s = 16'd0;

      // Reset takes priority over an enabled load.
      step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 16'hFFFF);
      chk_en = 1'b1;
      check("rst_pout", 64'(pout8), 64'h0);
      check("rst_fill", 64'(fill8), 64'h0);
      check("rst_full", 64'(full8), 64'h0);
      check("rst_vld",  64'(vld8),  64'h0);

      // Eight shift-rights fill the register; nothing is flagged valid yet.
      seq = 8'b0100_1101;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 2'd1, seq[i], 1'b0, 16'h0);
         check("fill_vld0", 64'(vld8), 64'h0);
      end
      check("shr8_pout", 64'(pout8), 64'h4D);
      check("shr8_fill", 64'(fill8), 64'd8);
      check("shr8_full", 64'(full8), 64'h1);

      step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'h0);
      check("shr9_sout", 64'(sout8), 64'h1);
      check("shr9_vld",  64'(vld8),  64'h1);
      check("shr9_pout", 64'(pout8), 64'hA6);
      step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0);
      check("hold_vld", 64'(vld8), 64'h0);

      // Load then shift-left.
      step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'h00A5);
      check("load_vld", 64'(vld8), 64'h0);
      step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0);
      check("shl_sout", 64'(sout8), 64'h1);
      check("shl_vld",  64'(vld8),  64'h1);
      check("shl_pout", 64'(pout8), 64'h4A);
      check("shl_fill", 64'(fill8), 64'd8);

      // Reset mid-fill together with a load request.
      step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'h0);
      check("mid_fill", 64'(fill8), 64'd5);
      step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 16'h1234);
      check("mid_rst_pout", 64'(pout8), 64'h0);
      check("mid_rst_fill", 64'(fill8), 64'h0);
      check("mid_rst_sout", 64'(sout8), 64'h0);
      step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'h0);
      check("post_rst_vld",  64'(vld8),  64'h0);
      check("post_rst_fill", 64'(fill8), 64'd1);

      // Enable low freezes state even with a shift mode selected.
      keep_pout = pout8;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0);
         check("en0_pout", 64'(pout8), 64'h80);
         check("en0_fill", 64'(fill8), 64'd1);
         check("en0_vld",  64'(vld8),  64'h0);
      end
      check("en0_keep", 64'(pout8), 64'(keep_pout));

      // Saturation on the 16-bit instance.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'h0);
      check("sat16_fill", 64'(fill16), 64'd16);
      check("sat16_full", 64'(full16), 64'h1);

      // Randomised traffic with occasional reset.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
              2'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 16'($urandom));
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register length in bits, legal range 2..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port en, input, 1: operation enable; 0 freezes all state.
REQ-005 SHALL have port mode, input, 2: operation select, 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 SHALL have port din_r, input, 1: serial input entering at the MSB on shift right.
REQ-007 SHALL have port din_l, input, 1: serial input entering at the LSB on shift left.
REQ-008 SHALL have port pdin, input, WIDTH: parallel load data.
REQ-009 SHALL have port pout, output, WIDTH: current register contents, registered.
REQ-010 SHALL have port sout, output, 1: bit shifted out on the last shift, registered.
REQ-011 SHALL have port sout_vld, output, 1: sout carries a bit that was filled before it was shifted out.
REQ-012 SHALL have port fill, output, $clog2(WIDTH+1): count of valid bits held, 0..WIDTH.
REQ-013 SHALL have port full, output, 1: high when fill == WIDTH.

Function
REQ-014 Shift right (en=1, mode=01) SHALL set reg <= {din_r, reg[WIDTH-1:1]} and sout <= reg[0].
REQ-015 Shift left (en=1, mode=10) SHALL set reg <= {reg[WIDTH-2:0], din_l} and sout <= reg[WIDTH-1].
REQ-016 On either shift, sout_vld SHALL take the value full had before the edge, so no unfilled bit is ever flagged valid.
REQ-017 On either shift, fill SHALL increment by 1 and saturate at WIDTH; it SHALL never wrap.
REQ-018 Parallel load (en=1, mode=11) SHALL set reg <= pdin, fill <= WIDTH and sout_vld <= 0, with sout unchanged.
REQ-019 Hold (mode=00) and en=0 SHALL leave reg, fill and sout unchanged and force sout_vld <= 0.
REQ-020 sout_vld SHALL be a one-cycle pulse per shift and SHALL never stay high without a shift.
REQ-021 All outputs SHALL be registered, with one-cycle latency from the qualifying edge.
REQ-022 full SHALL be derived from the fill register, with no extra cycle of delay.
REQ-023 Any change of mode between cycles SHALL take effect on the next edge, with no flush and no bubble.

Reset
REQ-024 When rst=1 at a rising clk edge, pout, sout, sout_vld and fill SHALL be 0 and full SHALL be 0.
REQ-025 rst SHALL take priority over en and mode, including in the middle of a fill or a shift sequence.
REQ-026 The first shift after reset SHALL produce sout_vld=0 until WIDTH shifts have completed.

Structure
REQ-027 Package univ_shift_pkg SHALL hold the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD.
REQ-028 The fill counter and full flag SHALL be implemented in one sub-module, shift_fill_cnt, parameterised by WIDTH, with inputs clk, rst, inc and load.
REQ-029 No latches or asynchronous logic SHALL be used, and no state SHALL be initialised by declaration.

Verification
REQ-030 WIDTH=8, reset, then 8 shift-rights with din_r = 1,0,1,1,0,0,1,0 -> pout=8'h4D, fill=8, full=1, sout_vld=0 throughout.
REQ-031 Continuing REQ-030, one more shift-right with din_r=1 -> sout=1, sout_vld=1 for one cycle, pout=8'hA6.
REQ-032 Load pdin=8'hA5, then shift-left with din_l=0 -> sout=1, sout_vld=1, pout=8'h4A, fill=8.
REQ-033 After 5 shifts (fill=5), assert rst for one cycle together with mode=11 -> all outputs 0, fill=0; the next shift gives sout_vld=0.
REQ-034 en=0 with mode=01 for 3 cycles -> pout and fill unchanged, sout_vld=0; then saturation check: 20 shifts at WIDTH=16 -> fill stays 16.
